// File: rtl/l1_refill_pkg.sv
// Shared constants for the L1 bus-side refill sequencer: state encoding,
// request opcodes and default geometry shared with the L1.
package l1_refill_pkg;

    localparam int unsigned DEF_ADDR_WIDTH     = 24;
    localparam int unsigned DEF_LINE_WID       = 7;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_LINE   = 3'd1,
        ST_RD_SINGLE = 3'd2,
        ST_WR_SINGLE = 3'd3,
        ST_DONE      = 3'd4,
        ST_ERR       = 3'd5
    } state_t;

    localparam logic [1:0] OP_NONE   = 2'd0;
    localparam logic [1:0] OP_WT     = 2'd1;
    localparam logic [1:0] OP_LINE   = 2'd2;
    localparam logic [1:0] OP_SINGLE = 2'd3;

    // Write-through wins over line refill, which wins over a single read.
    function automatic logic [1:0] req_op(input logic wt, input logic line, input logic rd);
        if (wt)   return OP_WT;
        if (line) return OP_LINE;
        if (rd)   return OP_SINGLE;
        return OP_NONE;
    endfunction

endpackage

// File: rtl/l1_refill_ctrl_if.sv
// Single-beat 8-bit system bus seen by the refill sequencer (master) and the
// bus fabric (slave).
interface l1_refill_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = l1_refill_pkg::DEF_ADDR_WIDTH
);
    logic                  bus_req;
    logic                  bus_we;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [7:0]            bus_wdata;
    logic [7:0]            bus_rdata;
    logic                  bus_ack;
    logic                  bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack, bus_err
    );
endinterface

// File: rtl/l1_refill_watchdog.sv
// Per-beat timeout counter; flags a beat that has waited TIMEOUT_CYCLES
// request cycles without ack or err. Used only with L1_REFILL_TIMEOUT_EN.
module l1_refill_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = l1_refill_pkg::DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic beat_active,
    input  logic beat_done,
    output logic timeout_c
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt;

    assign timeout_c = beat_active && !beat_done && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!beat_active || beat_done || timeout_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/l1_refill_ctrl.sv
// Bus-side sequencer for the unified L1: turns write-through, single-read and
// line-refill requests into single-byte bus beats. Optional beat timeout: L1_REFILL_TIMEOUT_EN.
module l1_refill_ctrl
    import l1_refill_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned LINE_WID       = DEF_LINE_WID,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_through_req,
    input  logic                  read_req,
    input  logic                  read_line_req,
    input  logic [ADDR_WIDTH-1:0] pa,
    input  logic [7:0]            wt_data,
    output logic [7:0]            line_data,
    output logic [LINE_WID-1:0]   addr_count,
    output logic                  line_write,
    output logic                  cache_entry_refill,
    output logic                  trans_rdy,
    output logic                  bus_error,
    l1_refill_ctrl_if.master      bus
);
    state_t                state;
    logic [ADDR_WIDTH-1:0] pa_q;
    logic [LINE_WID-1:0]   beat_idx;
    logic                  timeout_c;
    logic                  beat_fail_c;

`ifdef L1_REFILL_TIMEOUT_EN
    l1_refill_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .beat_active(bus.bus_req),
        .beat_done  (bus.bus_ack | bus.bus_err),
        .timeout_c  (timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    // A timed-out beat is handled exactly like a bus error.
    assign beat_fail_c = bus.bus_err | timeout_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= ST_IDLE;
            pa_q               <= '0;
            beat_idx           <= '0;
            line_data          <= '0;
            addr_count         <= '0;
            line_write         <= 1'b0;
            cache_entry_refill <= 1'b0;
            trans_rdy          <= 1'b0;
            bus_error          <= 1'b0;
            bus.bus_req        <= 1'b0;
            bus.bus_we         <= 1'b0;
            bus.bus_addr       <= '0;
            bus.bus_wdata      <= '0;
        end else begin
            line_write         <= 1'b0;
            cache_entry_refill <= 1'b0;
            trans_rdy          <= 1'b0;
            bus_error          <= 1'b0;

            case (state)
                ST_IDLE: begin
                    pa_q     <= pa;
                    beat_idx <= '0;
                    case (req_op(write_through_req, read_line_req, read_req))
                        OP_WT: begin
                            state         <= ST_WR_SINGLE;
                            bus.bus_req   <= 1'b1;
                            bus.bus_we    <= 1'b1;
                            bus.bus_addr  <= pa;
                            bus.bus_wdata <= wt_data;
                        end
                        OP_LINE: begin
                            state        <= ST_RD_LINE;
                            bus.bus_req  <= 1'b1;
                            bus.bus_we   <= 1'b0;
                            bus.bus_addr <= {pa[ADDR_WIDTH-1:LINE_WID], LINE_WID'(0)};
                        end
                        OP_SINGLE: begin
                            state        <= ST_RD_SINGLE;
                            bus.bus_req  <= 1'b1;
                            bus.bus_we   <= 1'b0;
                            bus.bus_addr <= pa;
                        end
                        default: ;
                    endcase
                end

                // Beat gap cycle re-issues the request at the next line offset.
                ST_RD_LINE: begin
                    if (!bus.bus_req) begin
                        bus.bus_req  <= 1'b1;
                        bus.bus_addr <= {pa_q[ADDR_WIDTH-1:LINE_WID], beat_idx};
                    end else if (beat_fail_c) begin
                        bus.bus_req <= 1'b0;
                        bus_error   <= 1'b1;
                        state       <= ST_ERR;
                    end else if (bus.bus_ack) begin
                        bus.bus_req <= 1'b0;
                        line_data   <= bus.bus_rdata;
                        addr_count  <= beat_idx;
                        line_write  <= 1'b1;
                        if (beat_idx == {LINE_WID{1'b1}}) begin
                            cache_entry_refill <= 1'b1;
                            trans_rdy          <= 1'b1;
                            state              <= ST_DONE;
                        end else begin
                            beat_idx <= beat_idx + LINE_WID'(1);
                        end
                    end
                end

                ST_RD_SINGLE: begin
                    if (beat_fail_c) begin
                        bus.bus_req <= 1'b0;
                        bus_error   <= 1'b1;
                        state       <= ST_ERR;
                    end else if (bus.bus_ack) begin
                        bus.bus_req <= 1'b0;
                        line_data   <= bus.bus_rdata;
                        trans_rdy   <= 1'b1;
                        state       <= ST_DONE;
                    end
                end

                ST_WR_SINGLE: begin
                    if (beat_fail_c) begin
                        bus.bus_req <= 1'b0;
                        bus.bus_we  <= 1'b0;
                        bus_error   <= 1'b1;
                        state       <= ST_ERR;
                    end else if (bus.bus_ack) begin
                        bus.bus_req <= 1'b0;
                        bus.bus_we  <= 1'b0;
                        trans_rdy   <= 1'b1;
                        state       <= ST_DONE;
                    end
                end

                // Requests are not sampled here; the L1 drops them on trans_rdy.
                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Directed bench for l1_refill_ctrl: queue-based expectation model of beats,
// line writes and completion strobes, checked every cycle, plus literal latency pins.
module tb_l1_refill_ctrl;
    localparam int unsigned AW = 24;
    localparam int unsigned LW = 7;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          write_through_req, read_req, read_line_req;
    logic [AW-1:0] pa;
    logic [7:0]    wt_data;
    logic [7:0]    line_data;
    logic [LW-1:0] addr_count;
    logic          line_write, cache_entry_refill, trans_rdy, bus_error;

    l1_refill_ctrl_if #(.ADDR_WIDTH(AW)) bif ();

    l1_refill_ctrl #(.ADDR_WIDTH(AW), .LINE_WID(LW), .TIMEOUT_CYCLES(TO)) dut (
        .clk               (clk),
        .rst               (rst),
        .write_through_req (write_through_req),
        .read_req          (read_req),
        .read_line_req     (read_line_req),
        .pa                (pa),
        .wt_data           (wt_data),
        .line_data         (line_data),
        .addr_count        (addr_count),
        .line_write        (line_write),
        .cache_entry_refill(cache_entry_refill),
        .trans_rdy         (trans_rdy),
        .bus_error         (bus_error),
        .bus               (bif.master)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expectation model: beats the bus must see, bytes the L1 must receive,
    // and completion kinds (1 = trans_rdy, 2 = refill + trans_rdy, 3 = bus_error).
    typedef struct packed { logic [AW-1:0] addr; logic we; logic [7:0] wdata; } beat_t;
    typedef struct packed { logic [LW-1:0] idx; logic [7:0] data; } lw_t;
    beat_t exp_beats[$];
    lw_t   exp_lw[$];
    int    exp_done[$];

    // Bus slave configuration and observation counters
    int         wait_n = 0;
    int         err_beat = -1;
    bit         no_ack = 1'b0;
    bit         addr_data = 1'b0;
    logic [7:0] rd_val = 8'h00;
    int         beat_no = 0;
    int         req_cyc = 0;
    int         last_hold = 0;
    int         req_hi = 0;
    int         lw_seen = 0;
    beat_t      held;

    task automatic model_single(input logic [AW-1:0] a, input bit we, input logic [7:0] d);
        exp_beats.push_back('{addr: a, we: we, wdata: d});
        exp_done.push_back(1);
    endtask

    task automatic model_line(input logic [AW-1:0] a, input int err_at);
        logic [AW-1:0] base;
        int nb, nw;
        base = (a >> LW) << LW;
        nb = (err_at < 0) ? (1 << LW) : err_at + 1;
        nw = (err_at < 0) ? (1 << LW) : err_at;
        for (int i = 0; i < nb; i++) exp_beats.push_back('{addr: base + AW'(i), we: 1'b0, wdata: 8'h00});
        for (int i = 0; i < nw; i++) exp_lw.push_back('{idx: LW'(i), data: 8'(base + AW'(i))});
        exp_done.push_back((err_at < 0) ? 2 : 3);
    endtask

    task automatic model_empty(input string tag);
        chk({tag, " leftover beats"}, 32'(exp_beats.size()), 0);
        chk({tag, " leftover line writes"}, 32'(exp_lw.size()), 0);
        chk({tag, " leftover completions"}, 32'(exp_done.size()), 0);
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, " strobes"}, {28'd0, line_write, cache_entry_refill, trans_rdy, bus_error}, 0);
        chk({tag, " line_data/addr_count"}, {17'd0, line_data, addr_count}, 0);
        chk({tag, " bus_req/we"}, {30'd0, bif.bus_req, bif.bus_we}, 0);
        chk({tag, " bus_addr"}, 32'(bif.bus_addr), 0);
        chk({tag, " bus_wdata"}, 32'(bif.bus_wdata), 0);
    endtask

    // Waits for trans_rdy or bus_error; lat counts negedges after the request was raised.
    task automatic wait_done(input int budget, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(trans_rdy || bus_error) && lat < budget);
        #1;
        if (!(trans_rdy || bus_error)) chk("completion within budget", 0, 1);
    endtask

    // Compare process and bus slave: one pass per negedge.
    initial begin
        bif.bus_ack   = 1'b0;
        bif.bus_err   = 1'b0;
        bif.bus_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                req_cyc     = 0;
                bif.bus_ack = 1'b0;
                bif.bus_err = 1'b0;
                continue;
            end
            if (line_write) begin
                lw_seen++;
                if (exp_lw.size() == 0) chk("unexpected line_write", 1, 0);
                else begin
                    lw_t e;
                    e = exp_lw.pop_front();
                    chk("addr_count", 32'(addr_count), 32'(e.idx));
                    chk("line_data on line_write", 32'(line_data), 32'(e.data));
                end
            end
            if (trans_rdy || cache_entry_refill || bus_error) begin
                if (exp_done.size() == 0)
                    chk("unexpected completion strobe", {29'd0, trans_rdy, cache_entry_refill, bus_error}, 0);
                else begin
                    int code;
                    code = exp_done.pop_front();
                    chk("completion strobes {rdy,refill,err}", {29'd0, trans_rdy, cache_entry_refill, bus_error},
                        (code == 1) ? 32'b100 : (code == 2) ? 32'b110 : 32'b001);
                end
            end
            bif.bus_ack = 1'b0;
            bif.bus_err = 1'b0;
            if (bif.bus_req) begin
                req_hi++;
                if (req_cyc > 0) begin
                    chk("beat addr stable", 32'(bif.bus_addr), 32'(held.addr));
                    chk("beat we/wdata stable", {23'd0, bif.bus_we, bif.bus_wdata}, {23'd0, held.we, held.wdata});
                end else begin
                    held = '{addr: bif.bus_addr, we: bif.bus_we, wdata: bif.bus_wdata};
                end
                req_cyc++;
                if (!no_ack && req_cyc == wait_n + 1) begin
                    if (exp_beats.size() == 0) chk("unexpected beat", 1, 0);
                    else begin
                        beat_t b;
                        b = exp_beats.pop_front();
                        chk("beat addr", 32'(bif.bus_addr), 32'(b.addr));
                        chk("beat we", 32'(bif.bus_we), 32'(b.we));
                        if (b.we) chk("beat wdata", 32'(bif.bus_wdata), 32'(b.wdata));
                    end
                    if (beat_no == err_beat) bif.bus_err = 1'b1;
                    else begin
                        bif.bus_ack   = 1'b1;
                        bif.bus_rdata = addr_data ? bif.bus_addr[7:0] : rd_val;
                    end
                    beat_no++;
                    last_hold = req_cyc;
                    req_cyc   = 0;
                end
            end else begin
                req_cyc = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int lat, lw0, budget;
        rst = 1'b1;
        write_through_req = 1'b0; read_req = 1'b0; read_line_req = 1'b0;
        pa = '0; wt_data = 8'h00;
        repeat (3) @(negedge clk);
        #1 outs_zero("reset");
        @(negedge clk) rst = 1'b0;

        // Single read, zero wait
        beat_no = 0; rd_val = 8'hA5;
        model_single(24'h001234, 1'b0, 8'h00);
        @(negedge clk);
        pa = 24'h001234; read_req = 1'b1;
        wait_done(10, lat);
        read_req = 1'b0; pa = 24'hFFFFFF;
        chk("read latency", 32'(lat), 2);
        chk("read line_data", 32'(line_data), 32'hA5);
        repeat (2) @(negedge clk);
        #1 chk("read line_data held in idle", 32'(line_data), 32'hA5);
        chk("read no line_write", 32'(lw_seen), 0);
        model_empty("read");

        // Write-through with 3 wait states; pa/wt_data change mid-beat
        beat_no = 0; wait_n = 3;
        model_single(24'h00FF01, 1'b1, 8'h3C);
        @(negedge clk);
        pa = 24'h00FF01; wt_data = 8'h3C; write_through_req = 1'b1;
        @(negedge clk);
        pa = 24'hABCDEF; wt_data = 8'h00;
        wait_done(20, lat);
        write_through_req = 1'b0;
        chk("write latency", 32'(lat + 1), 5);
        chk("write bus_req hold cycles", 32'(last_hold), 4);
        wait_n = 0;
        repeat (2) @(negedge clk);
        model_empty("write");

        // Full line refill, data = low address byte
        beat_no = 0; addr_data = 1'b1; lw0 = lw_seen;
        model_line(24'h012345, -1);
        @(negedge clk);
        pa = 24'h012345; read_line_req = 1'b1;
        wait_done(400, lat);
        read_line_req = 1'b0;
        chk("line latency", 32'(lat), 256);
        chk("line write count", 32'(lw_seen - lw0), 128);
        repeat (2) @(negedge clk);
        model_empty("line");

        // Line refill failing on beat 40, then a normal read
        beat_no = 0; err_beat = 40;
        model_line(24'h00AA80, 40);
        @(negedge clk);
        pa = 24'h00AA80; read_line_req = 1'b1;
        wait_done(200, lat);
        read_line_req = 1'b0;
        chk("error latency", 32'(lat), 82);
        chk("bus_req low after error", 32'(bif.bus_req), 0);
        err_beat = -1;
        repeat (2) @(negedge clk);
        model_empty("line error");
        beat_no = 0; addr_data = 1'b0; rd_val = 8'h5A;
        model_single(24'h000077, 1'b0, 8'h00);
        @(negedge clk);
        pa = 24'h000077; read_req = 1'b1;
        wait_done(10, lat);
        read_req = 1'b0;
        chk("read after error latency", 32'(lat), 2);
        chk("read after error line_data", 32'(line_data), 32'h5A);
        repeat (2) @(negedge clk);
        model_empty("read after error");

        // Write and line together: write first, then line cut by reset at beat 10
        beat_no = 0; addr_data = 1'b1; lw0 = lw_seen;
        model_single(24'h000280, 1'b1, 8'h11);
        model_line(24'h000280, -1);
        @(negedge clk);
        pa = 24'h000280; wt_data = 8'h11; write_through_req = 1'b1; read_line_req = 1'b1;
        wait_done(10, lat);
        write_through_req = 1'b0;
        chk("priority write latency", 32'(lat), 2);
        budget = 0;
        while (lw_seen - lw0 < 10 && budget < 100) begin
            @(negedge clk);
            #1 budget++;
        end
        chk("line writes before reset", 32'(lw_seen - lw0), 10);
        rst = 1'b1;
        #1 outs_zero("async reset mid-line");
        exp_beats.delete(); exp_lw.delete(); exp_done.delete();
        read_line_req = 1'b0;
        @(negedge clk) rst = 1'b0;
        addr_data = 1'b0;

        // Bus that never answers
        beat_no = 0; no_ack = 1'b1;
        @(negedge clk);
        pa = 24'h000100; read_req = 1'b1;
        req_hi = 0;
`ifdef L1_REFILL_TIMEOUT_EN
        exp_done.push_back(3);
        wait_done(50, lat);
        read_req = 1'b0;
        chk("timeout latency", 32'(lat), 9);
        chk("timeout bus_req cycles", 32'(req_hi), TO);
        repeat (2) @(negedge clk);
`else
        repeat (1000) @(negedge clk);
        #1 chk("no-ack bus_req cycles", 32'(req_hi), 1000);
        rst = 1'b1;
        read_req = 1'b0;
        @(negedge clk) rst = 1'b0;
`endif
        no_ack = 1'b0;
        model_empty("no ack");

        // Normal read after recovery
        beat_no = 0; rd_val = 8'h77;
        model_single(24'h00ABCD, 1'b0, 8'h00);
        @(negedge clk);
        pa = 24'h00ABCD; read_req = 1'b1;
        wait_done(10, lat);
        read_req = 1'b0;
        chk("recovery read latency", 32'(lat), 2);
        chk("recovery line_data", 32'(line_data), 32'h77);
        repeat (2) @(negedge clk);
        model_empty("recovery");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
